// File: rtl/power_est_pkg.sv
// power_est_pkg
//   Shared definitions for the activity-monitor blocks.
//   MODE_WRAP / MODE_SAT : boundary behaviour of counters.
//   clog2(v)             : ceil(log2(v)); callers use clog2(WIDTH+1) to size
//                          a ones-count so that it can hold the value WIDTH.
package power_est_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic int clog2(input longint v);
    int     r;
    longint p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/popcount.sv
// popcount
//   Combinational ones counter, shared by the activity monitors.
//   Ports:
//     vec  in  WIDTH  vector to count
//     ones out OW     number of set bits in vec (OW = clog2(WIDTH+1))
module popcount
  import power_est_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int OW    = clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [OW-1:0]    ones
);

  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + OW'(vec[i]);
    end
  end

endmodule

// File: rtl/counter_act.sv
// counter_act
//   Modulo up/down counter with synchronous load, wrap or saturate boundary
//   handling, a registered terminal-count pulse, and a saturating accumulator
//   of bit toggles on the count register (ground truth for power estimation).
//   Ports:
//     clk         in   1      clock, all state on rising edge
//     rst         in   1      synchronous active-high reset, overrides all
//     en          in   1      count enable
//     up_dn       in   1      1 = up, 0 = down (used only when en=1)
//     load        in   1      synchronous load, wins over en
//     load_val    in   WIDTH  load value, clamped to MOD-1
//     toggle_clr  in   1      synchronous clear of toggle_cnt
//     count       out  WIDTH  current count
//     tc          out  1      high while count shows a post-boundary value
//     toggle_cnt  out  ACC_W  accumulated count-register toggles, saturating
module counter_act
  import power_est_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MOD      = 16,
  parameter int     SAT_MODE = MODE_WRAP,
  parameter int     ACC_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             toggle_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic [ACC_W-1:0] toggle_cnt
);

  localparam int               DW      = clog2(WIDTH + 1);
  // Compared at WIDTH bits: MOD = 2**WIDTH makes this all-ones.
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MOD - 1);
  localparam logic             SAT     = (SAT_MODE == MODE_SAT);

  logic [WIDTH-1:0] count_next;
  logic             tc_next;
  logic [DW-1:0]    delta;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_sat;

  always_comb begin
    count_next = count;
    tc_next    = 1'b0;
    if (load) begin
      count_next = (load_val > CNT_MAX) ? CNT_MAX : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (count == CNT_MAX) begin
          count_next = SAT ? CNT_MAX : '0;
          tc_next    = 1'b1;
        end else begin
          count_next = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          count_next = SAT ? '0 : CNT_MAX;
          tc_next    = 1'b1;
        end else begin
          count_next = count - WIDTH'(1);
        end
      end
    end
  end

  popcount #(.WIDTH(WIDTH)) u_popcount (
    .vec  (count_next ^ count),
    .ones (delta)
  );

  // One extra bit on the adder exposes overflow for saturation.
  always_comb begin
    acc_sum = {1'b0, toggle_cnt} + (ACC_W + 1)'(delta);
    acc_sat = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      tc         <= 1'b0;
      toggle_cnt <= '0;
    end else begin
      count      <= count_next;
      tc         <= tc_next;
      toggle_cnt <= toggle_clr ? '0 : acc_sat;
    end
  end

endmodule
